// File: rtl/stream_pass_checker_p_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_chk_pkg : character class / matcher state types and helpers  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package stream_chk_pkg;

    typedef enum logic [1:0] {
        CL_VOWEL = 2'd0,
        CL_CONS  = 2'd1,
        CL_OTHER = 2'd2
    } char_class_t;

    typedef enum logic [1:0] {
        S_CHECK = 2'd0,
        S_PASS  = 2'd1,
        S_FAIL  = 2'd2
    } pm_state_t;

    function automatic logic [6:0] fold_case(input logic [6:0] c);
        logic [6:0] r;
        r = c;
        if (c >= 7'h41 && c <= 7'h5a) begin
            r = c | 7'h20;
        end
        return r;
    endfunction

    // Letters are classified regardless of case; only storage/compare depend on folding.
    function automatic char_class_t classify(input logic [6:0] c);
        logic [6:0]  l;
        char_class_t r;
        l = fold_case(c);
        if (l < 7'h61 || l > 7'h7a) begin
            r = CL_OTHER;
        end else begin
            case (l)
                7'h61, 7'h65, 7'h69, 7'h6f, 7'h75: r = CL_VOWEL;
                default:                           r = CL_CONS;
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_pass_checker_p_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_pass_checker_p_if : valid/ready byte stream                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface stream_pass_checker_p_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/stream_pass_checker_p_char_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | char_buffer : non-wrapping append buffer with count, full flag and  |
// | registered read port. Rev 1.0                                      |
// +--------------------------------------------------------------------+
module char_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  wire                         clk,
    input  wire                         reset,
    input  wire                         clear,
    input  wire                         wr_en,
    input  wire  [DATA_W-1:0]           wr_data,
    input  wire  [$clog2(DEPTH)-1:0]    rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_full;
    logic              w_write;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_write = wr_en && !w_full;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_count[AW-1:0]] <= wr_data;
        end
    end

    // Same-edge read sees the pre-write contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_write) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign rd_data = r_rd_data;
    assign count   = r_count;
    assign full    = w_full;
endmodule
`default_nettype wire

// File: rtl/stream_pass_checker_p.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_pass_checker_p : classifies a byte stream into vowel and     |
// | consonant buffers and matches a password. Rev 1.0                  |
// +--------------------------------------------------------------------+
module stream_pass_checker_p
    import stream_chk_pkg::*;
#(
    parameter int                         DATA_W   = 8,
    parameter int                         DEPTH    = 64,
    parameter int                         PASS_LEN = 4,
    parameter logic [PASS_LEN*DATA_W-1:0] PASSWORD = "pass",
    parameter int                         MODE     = 0,
    parameter int                         CASE_INS = 1
) (
    input  wire                          clk,
    input  wire                          reset,
    input  wire                          clear,
    stream_pass_checker_p_if.slave       in_s,
    input  wire                          rd_sel,
    input  wire  [$clog2(DEPTH)-1:0]     rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   cons_count,
    output logic [$clog2(DEPTH+1)-1:0]   vow_count,
    output logic                         cons_full,
    output logic                         vow_full,
    output logic                         match,
    output logic                         fail
);
    localparam int PW = PASS_LEN * DATA_W;

    char_class_t       w_class;
    logic [DATA_W-1:0] w_folded;
    logic              w_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_cons_rd;
    logic [DATA_W-1:0] w_vow_rd;
    logic              r_rd_sel;

    assign w_class = classify(in_s.in_data[6:0]);

    if (CASE_INS != 0) begin : g_fold
        assign w_folded = {in_s.in_data[DATA_W-1:7], fold_case(in_s.in_data[6:0])};
    end else begin : g_raw
        assign w_folded = in_s.in_data;
    end

    // Only the class whose buffer is full stalls; 'other' chars never do.
    always_comb begin
        w_ready = !clear;
        case (w_class)
            CL_VOWEL: if (vow_full)  w_ready = 1'b0;
            CL_CONS:  if (cons_full) w_ready = 1'b0;
            default:  ;
        endcase
    end

    assign in_s.in_ready = w_ready;
    assign w_accept      = in_s.in_valid && w_ready;

    char_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_cons_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (w_accept && (w_class == CL_CONS)),
        .wr_data (w_folded),
        .rd_addr (rd_addr),
        .rd_data (w_cons_rd),
        .count   (cons_count),
        .full    (cons_full)
    );

    char_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_vow_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (w_accept && (w_class == CL_VOWEL)),
        .wr_data (w_folded),
        .rd_addr (rd_addr),
        .rd_data (w_vow_rd),
        .count   (vow_count),
        .full    (vow_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_sel <= 1'b0;
        end else begin
            r_rd_sel <= rd_sel;
        end
    end

    assign rd_data = r_rd_sel ? w_vow_rd : w_cons_rd;

    if (MODE == 0) begin : g_sliding
        localparam int FILL_W = $clog2(PASS_LEN + 1);

        logic [PW-1:0]        r_window;
        logic [FILL_W-1:0]    r_fill;
        logic                 r_match;
        logic [PW+DATA_W-1:0] w_shift;
        logic [PW-1:0]        w_next_window;
        logic                 w_hit;

        assign w_shift       = {r_window, w_folded};
        assign w_next_window = w_shift[PW-1:0];
        assign w_hit = (w_next_window == PASSWORD) && (r_fill >= FILL_W'(PASS_LEN - 1));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_window <= '0;
                r_fill   <= '0;
                r_match  <= 1'b0;
            end else if (clear) begin
                r_window <= '0;
                r_fill   <= '0;
                r_match  <= 1'b0;
            end else begin
                r_match <= w_accept && w_hit;
                if (w_accept) begin
                    r_window <= w_next_window;
                    if (r_fill != FILL_W'(PASS_LEN)) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end
            end
        end

        assign match = r_match;
        assign fail  = 1'b0;
    end else begin : g_anchored
        localparam int IDX_W = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;

        pm_state_t         r_state;
        pm_state_t         w_state_nxt;
        logic [IDX_W-1:0]  r_idx;
        logic [IDX_W-1:0]  w_idx_nxt;
        logic [PW-1:0]     w_pw_shift;
        logic [DATA_W-1:0] w_exp_char;
        logic              w_match;
        logic              w_fail;

        // PASSWORD holds char #0 in its MS byte.
        assign w_pw_shift = PASSWORD << (DATA_W * int'(r_idx));
        assign w_exp_char = w_pw_shift[PW-1 -: DATA_W];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= S_CHECK;
                r_idx   <= '0;
            end else if (clear) begin
                r_state <= S_CHECK;
                r_idx   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_idx   <= w_idx_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_idx_nxt   = r_idx;
            case (r_state)
                S_CHECK: begin
                    if (w_accept) begin
                        if (w_folded != w_exp_char) begin
                            w_state_nxt = S_FAIL;
                        end else if (r_idx == IDX_W'(PASS_LEN - 1)) begin
                            w_state_nxt = S_PASS;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        always_comb begin
            w_match = 1'b0;
            w_fail  = 1'b0;
            case (r_state)
                S_PASS:  w_match = 1'b1;
                S_FAIL:  w_fail  = 1'b1;
                default: ;
            endcase
        end

        assign match = w_match;
        assign fail  = w_fail;
    end
endmodule
`default_nettype wire

// File: tb/tb_stream_pass_checker_p.sv
`default_nettype none
// Directed bench: three DUT configurations (sliding, anchored, DEPTH=4) share one stimulus stream.
module tb_stream_pass_checker_p;
    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       rd_sel;
    logic [5:0] rd_addr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_pass_checker_p_if #(.DATA_W(8)) if0 ();
    stream_pass_checker_p_if #(.DATA_W(8)) if1 ();
    stream_pass_checker_p_if #(.DATA_W(8)) if2 ();

    assign if0.in_valid = in_valid;
    assign if0.in_data  = in_data;
    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;
    assign if2.in_valid = in_valid;
    assign if2.in_data  = in_data;

    logic [7:0] m0_rd, m1_rd, d4_rd;
    logic [6:0] m0_cons, m0_vow, m1_cons, m1_vow;
    logic [2:0] d4_cons, d4_vow;
    logic       m0_cf, m0_vf, m0_match, m0_fail;
    logic       m1_cf, m1_vf, m1_match, m1_fail;
    logic       d4_cf, d4_vf, d4_match, d4_fail;

    stream_pass_checker_p #(.DEPTH(64), .MODE(0)) u_m0 (
        .clk(clk), .reset(reset), .clear(clear), .in_s(if0.slave),
        .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(m0_rd),
        .cons_count(m0_cons), .vow_count(m0_vow), .cons_full(m0_cf), .vow_full(m0_vf),
        .match(m0_match), .fail(m0_fail)
    );

    stream_pass_checker_p #(.DEPTH(64), .MODE(1)) u_m1 (
        .clk(clk), .reset(reset), .clear(clear), .in_s(if1.slave),
        .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_data(m1_rd),
        .cons_count(m1_cons), .vow_count(m1_vow), .cons_full(m1_cf), .vow_full(m1_vf),
        .match(m1_match), .fail(m1_fail)
    );

    stream_pass_checker_p #(.DEPTH(4), .MODE(0)) u_d4 (
        .clk(clk), .reset(reset), .clear(clear), .in_s(if2.slave),
        .rd_sel(rd_sel), .rd_addr(rd_addr[1:0]), .rd_data(d4_rd),
        .cons_count(d4_cons), .vow_count(d4_vow), .cons_full(d4_cf), .vow_full(d4_vf),
        .match(d4_match), .fail(d4_fail)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the accept edge in between.
    task automatic send(input logic [7:0] c);
        in_valid = 1'b1;
        in_data  = c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rd_sel   = 1'b0;
        rd_addr  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cons",  {25'd0, m0_cons}, 0);
        chk("rst_vow",   {25'd0, m0_vow},  0);
        chk("rst_match", {31'd0, m0_match}, 0);
        chk("rst_fail",  {31'd0, m1_fail}, 0);
        chk("rst_rd",    {24'd0, m0_rd},   0);
        reset = 1'b1;

        // T1: "xpassy"
        send("x"); send("p"); send("a"); send("s");
        chk("t1_nomatch_early", {31'd0, m0_match}, 0);
        send("s");
        chk("t1_match", {31'd0, m0_match}, 1);
        send("y");
        chk("t1_pulse_end", {31'd0, m0_match}, 0);
        chk("t1_cons", {25'd0, m0_cons}, 5);
        chk("t1_vow",  {25'd0, m0_vow},  1);
        chk("t1_m1_fail", {31'd0, m1_fail}, 1);
        rd_sel = 1'b1; rd_addr = 6'd0;
        @(negedge clk);
        chk("t1_vow0", {24'd0, m0_rd}, 32'h61);
        rd_sel = 1'b0; rd_addr = 6'd1;
        @(negedge clk);
        chk("t1_cons1", {24'd0, m0_rd}, 32'h70);

        // T2: "passpass" then "PaSs"
        do_clear();
        chk("t2_clr_cons", {25'd0, m0_cons}, 0);
        send("p"); send("a"); send("s"); send("s");
        chk("t2_match1", {31'd0, m0_match}, 1);
        send("p");
        chk("t2_gap", {31'd0, m0_match}, 0);
        send("a"); send("s"); send("s");
        chk("t2_match2", {31'd0, m0_match}, 1);
        send("P"); send("a"); send("S");
        chk("t2_nomatch", {31'd0, m0_match}, 0);
        send("s");
        chk("t2_match3", {31'd0, m0_match}, 1);
        chk("t2_cons", {25'd0, m0_cons}, 9);
        chk("t2_vow",  {25'd0, m0_vow},  3);
        rd_sel = 1'b0; rd_addr = 6'd6;
        @(negedge clk);
        chk("t2_cons6_folded", {24'd0, m0_rd}, 32'h70);
        rd_addr = 6'd7;
        @(negedge clk);
        chk("t2_cons7_folded", {24'd0, m0_rd}, 32'h73);

        // T3: anchored mode
        do_clear();
        chk("t3_clr_fail", {31'd0, m1_fail}, 0);
        send("p"); send("a"); send("s");
        chk("t3_fail_pre", {31'd0, m1_fail}, 0);
        send("x");
        chk("t3_fail", {31'd0, m1_fail}, 1);
        send("p"); send("a"); send("s"); send("s");
        chk("t3_no_match", {31'd0, m1_match}, 0);
        chk("t3_fail_held", {31'd0, m1_fail}, 1);
        do_clear();
        chk("t3_fail_clr", {31'd0, m1_fail}, 0);
        send("p"); send("a"); send("s"); send("s");
        chk("t3_match", {31'd0, m1_match}, 1);
        send("z");
        chk("t3_match_held", {31'd0, m1_match}, 1);
        chk("t3_fail_zero", {31'd0, m1_fail}, 0);
        chk("t3_m0_fail_const", {31'd0, m0_fail}, 0);

        // T4: DEPTH=4 back-pressure on vowels
        do_clear();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = "e";
            #1;
            chk($sformatf("t4_ready_e%0d", i), {31'd0, if2.in_ready}, (i < 4) ? 1 : 0);
            @(negedge clk);
        end
        chk("t4_vow", {29'd0, d4_vow}, 4);
        chk("t4_vfull", {31'd0, d4_vf}, 1);
        in_data = "b";
        #1;
        chk("t4_ready_cons", {31'd0, if2.in_ready}, 1);
        @(negedge clk);
        chk("t4_cons", {29'd0, d4_cons}, 1);
        in_data = "o";
        #1;
        chk("t4_ready_o", {31'd0, if2.in_ready}, 0);
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("t4_ready_clr", {31'd0, if2.in_ready}, 0);
        @(negedge clk);
        clear = 1'b0;
        chk("t4_vow_clr", {29'd0, d4_vow}, 0);
        chk("t4_vfull_clr", {31'd0, d4_vf}, 0);
        #1;
        chk("t4_ready_after", {31'd0, if2.in_ready}, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t4_vow_5th", {29'd0, d4_vow}, 1);

        // T5: clear blocks accept; read-first on same-address write
        do_clear();
        send("k");
        chk("t5_cons_k", {25'd0, m0_cons}, 1);
        clear = 1'b1; in_valid = 1'b1; in_data = "c";
        #1;
        chk("t5_ready_clr", {31'd0, if0.in_ready}, 0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        chk("t5_cons_zero", {25'd0, m0_cons}, 0);
        rd_sel = 1'b0; rd_addr = 6'd0;
        send("m");
        chk("t5_read_first", {24'd0, m0_rd}, 32'h6b);
        @(negedge clk);
        chk("t5_read_new", {24'd0, m0_rd}, 32'h6d);

        // T6: async reset mid-password
        do_clear();
        send("p"); send("a");
        chk("t6_vow_pre", {25'd0, m0_vow}, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_vow_async", {25'd0, m0_vow}, 0);
        chk("t6_cons_async", {25'd0, m0_cons}, 0);
        chk("t6_rd_async", {24'd0, m0_rd}, 0);
        @(negedge clk);
        reset = 1'b1;
        send("s"); send("s");
        chk("t6_ss_nomatch", {31'd0, m0_match}, 0);
        chk("t6_m1_fail", {31'd0, m1_fail}, 1);
        send("p"); send("a"); send("s"); send("s");
        chk("t6_pass_match", {31'd0, m0_match}, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send("p"); send("a"); send("s"); send("s");
        chk("t6_m1_pass", {31'd0, m1_match}, 1);
        chk("t6_d4_fail", {31'd0, d4_fail}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
